// File: rtl/leb128_u32_stream_encoder.sv
// leb128_u32_stream_encoder
//
// Streams the LEB128 encoding of a 32-bit value, one byte per cycle, with
// valid/ready handshakes on both sides. Unsigned and signed (two's
// complement) encodings are supported. Each encoding is selected per value.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a value is offered on in_data/in_signed
//   in_ready   : the encoder accepts the offered value this cycle
//   in_data    : 32-bit value to encode
//   in_signed  : 1 = signed LEB128, 0 = unsigned (sampled with in_data)
//   out_valid  : out_byte holds an encoded byte
//   out_ready  : the consumer takes out_byte this cycle
//   out_byte   : encoded byte, bit7 = continuation, bits[6:0] = payload group
//   out_last   : out_byte is the final byte of the encoding
//   byte_cnt   : total length of the current encoding (1..5)
module leb128_u32_stream_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [2:0]  byte_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Number of bytes needed for v. Groups 0..3 may terminate the encoding;
  // group 4 always does, so the default is 5.
  function automatic logic [2:0] enc_len(input logic [31:0] v, input logic sgn);
    logic [2:0]         len;
    logic               done;
    logic               hit;
    logic signed [31:0] sv;
    logic signed [31:0] rest_s;
    logic [31:0]        rest_u;
    logic [31:0]        top;
    len  = 3'd5;
    done = 1'b0;
    sv   = v;
    for (int k = 0; k < 4; k++) begin
      rest_s = sv >>> (7 * k + 7);
      rest_u = v >> (7 * k + 7);
      // top[0] is bit 6 of group k, the sign bit of the emitted payload
      top    = v >> (7 * k + 6);
      if (sgn) begin
        hit = ((rest_s == 32'sd0) && !top[0]) ||
              ((rest_s == {32{1'b1}}) && top[0]);
      end else begin
        hit = (rest_u == 32'd0);
      end
      if (!done && hit) begin
        done = 1'b1;
        len  = 3'(k + 1);
      end
    end
    return len;
  endfunction

  // Move the next 7-bit group into bits[6:0]. The arithmetic shift for
  // signed values makes group 4 come out sign-extended for free.
  function automatic logic [31:0] shift7(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    logic signed [31:0] ash;
    logic [31:0]        res;
    sv  = v;
    ash = sv >>> 7;
    if (sgn) begin
      res = ash;
    end else begin
      res = v >> 7;
    end
    return res;
  endfunction

  state_e      state_q,     state_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q,  out_byte_d;
  logic        out_last_q,  out_last_d;
  logic [2:0]  cnt_q,       cnt_d;
  logic [2:0]  idx_q,       idx_d;
  logic [31:0] shift_q,     shift_d;
  logic        sign_q,      sign_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        xfer_s;
  logic [2:0]  nxt_idx_s;
  logic [2:0]  len_s;
  logic        nxt_last_s;

  // Handshake decode, next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    sign_d      = sign_q;

    // A new value may enter while the last byte of the previous one leaves.
    in_ready_s = (state_q == ST_IDLE) || (out_valid_q && out_last_q && out_ready);
    accept_s   = in_valid && in_ready_s;
    xfer_s     = out_valid_q && out_ready;
    nxt_idx_s  = idx_q + 3'd1;
    nxt_last_s = (nxt_idx_s == (cnt_q - 3'd1));
    len_s      = enc_len(in_data, in_signed);

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_last_d  = (len_s == 3'd1);
      out_byte_d  = {(len_s != 3'd1), in_data[6:0]};
      cnt_d       = len_s;
      idx_d       = 3'd0;
      shift_d     = shift7(in_data, in_signed);
      sign_d      = in_signed;
    end else if (xfer_s && out_last_q) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_byte_d  = 8'h00;
      cnt_d       = 3'd0;
      idx_d       = 3'd0;
      shift_d     = 32'd0;
      sign_d      = 1'b0;
    end else if (xfer_s) begin
      out_last_d  = nxt_last_s;
      out_byte_d  = {!nxt_last_s, shift_q[6:0]};
      idx_d       = nxt_idx_s;
      shift_d     = shift7(shift_q, sign_q);
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (xfer_s && out_last_q && !accept_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      cnt_q       <= 3'd0;
      idx_q       <= 3'd0;
      shift_q     <= 32'd0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sign_q      <= sign_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_leb128_u32_stream_encoder.sv
// Testbench for leb128_u32_stream_encoder: a reference model computes the
// byte sequence with plain integer arithmetic; a negedge monitor compares the
// DUT against the queued expectation on every cycle.
module tb_leb128_u32_stream_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [2:0]  byte_cnt;

  leb128_u32_stream_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   xfer_cnt;
  int   b2b_hits;
  logic bp_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: repeatedly peel off the low 7 bits of the value as a
  // 64-bit integer and stop once the remainder carries no more information.
  function automatic void model_encode(input logic [31:0] v, input logic s,
                                       output logic [39:0] pk, output int n);
    longint     x;
    logic [7:0] g;
    bit         done;
    pk   = 40'd0;
    n    = 0;
    done = 1'b0;
    if (s) x = longint'($signed(v));
    else   x = longint'({32'd0, v});
    while (!done && n < 5) begin
      g = 8'(x & 64'sd127);
      x = x >>> 7;
      if (s) done = (x == 0 && !g[6]) || (x == -1 && g[6]);
      else   done = (x == 0);
      if (!done) g = g | 8'h80;
      pk[8*n +: 8] = g;
      n++;
    end
  endfunction

  function automatic void model_push(input logic [31:0] v, input logic s);
    logic [39:0] pk;
    int          n;
    exp_t        e;
    model_encode(v, s, pk, n);
    for (int i = 0; i < n; i++) begin
      e.b    = pk[8*i +: 8];
      e.last = (i == n - 1);
      e.cnt  = 3'(n);
      exp_q.push_back(e);
    end
  endfunction

  // Per-cycle compare against the model queue.
  logic       prev_stall;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic [2:0] prev_cnt;
  initial begin
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    prev_last  = 1'b0;
    prev_cnt   = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_byte",  64'(out_byte),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_byte_cnt",  64'(byte_cnt),  64'd0);
      end else begin
        bit popped_last;
        popped_last = 1'b0;
        chk("in_ready", 64'(in_ready),
            64'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
        if (prev_stall) begin
          chk("stall_byte", 64'(out_byte), 64'(prev_byte));
          chk("stall_last", 64'(out_last), 64'(prev_last));
          chk("stall_cnt",  64'(byte_cnt), 64'(prev_cnt));
        end
        if (exp_q.size() > 0) begin
          chk("out_valid", 64'(out_valid), 64'd1);
          chk("out_byte",  64'(out_byte),  64'(exp_q[0].b));
          chk("out_last",  64'(out_last),  64'(exp_q[0].last));
          chk("byte_cnt",  64'(byte_cnt),  64'(exp_q[0].cnt));
          if (out_valid && out_ready) begin
            popped_last = exp_q[0].last;
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end else begin
          chk("idle_out_valid", 64'(out_valid), 64'd0);
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
        prev_cnt   = byte_cnt;
        if (in_valid && in_ready) begin
          if (popped_last) b2b_hits++;
          model_push(in_data, in_signed);
        end
      end
    end
  end

  // Consumer: always ready, or random backpressure when enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Offer one value and hold it until accepted; caller is just after a posedge.
  task automatic send(input logic [31:0] v, input logic s);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = v;
    in_signed = s;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = 32'hDEAD_BEEF;
    in_signed = ~s;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (!out_valid && exp_q.size() == 0) ok = 1'b1;
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  logic [31:0] tv_val [13] = '{32'd624485, 32'hFFFF_FFFF, 32'd0, 32'hFFFE_1DC0,
                               32'hFFFF_FFFF, 32'h0000_0040, 32'h8000_0000, 32'h0000_007F,
                               32'h0000_0080, 32'h0000_003F, 32'hFFFF_FFC0, 32'hFFFF_FFBF,
                               32'h0FFF_FFFF};
  logic        tv_sgn [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  int          tv_len [13] = '{3, 5, 1, 3, 1, 2, 5, 1, 2, 1, 1, 2, 4};
  logic [39:0] tv_pk  [13] = '{40'h00_0026_8EE5, 40'h0F_FFFF_FFFF, 40'h00_0000_0000,
                               40'h00_0078_BBC0, 40'h00_0000_007F, 40'h00_0000_00C0,
                               40'h78_8080_8080, 40'h00_0000_007F, 40'h00_0000_0180,
                               40'h00_0000_003F, 40'h00_0000_0040, 40'h00_0000_7FBF,
                               40'h00_7FFF_FFFF};

  initial begin
    logic [39:0] pk;
    int          n;
    int          start;
    tests     = 0;
    fails     = 0;
    xfer_cnt  = 0;
    b2b_hits  = 0;
    bp_en     = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pin the model to hand-computed encodings.
    for (int i = 0; i < 13; i++) begin
      model_encode(tv_val[i], tv_sgn[i], pk, n);
      chk("model_bytes", 64'(pk), 64'(tv_pk[i]));
      chk("model_len",   64'(n),  64'(tv_len[i]));
    end

    // Directed vectors, consumer always ready.
    for (int i = 0; i < 13; i++) begin
      send(tv_val[i], tv_sgn[i]);
      drain();
    end

    // Random backpressure on long encodings.
    bp_en = 1'b1;
    send(32'hFFFF_FFFF, 1'b0); drain();
    send(32'h8000_0000, 1'b1); drain();
    send(32'd624485,    1'b0); drain();
    bp_en = 1'b0;

    // Back-to-back encodings, without and with backpressure.
    b2b_hits = 0;
    send(32'd624485, 1'b0);
    send(32'hFFFE_1DC0, 1'b1);
    send(32'd0, 1'b0);
    drain();
    chk("b2b_hits", 64'(b2b_hits), 64'd2);
    bp_en    = 1'b1;
    b2b_hits = 0;
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0040, 1'b1);
    send(32'h0FFF_FFFF, 1'b0);
    drain();
    chk("b2b_hits_bp", 64'(b2b_hits), 64'd2);
    bp_en = 1'b0;

    // Reset after the second byte of a 5-byte encoding.
    start = xfer_cnt;
    send(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 20 && xfer_cnt < start + 2; i++) begin
      @(posedge clk);
      #2;
    end
    chk("mid_xfers", 64'(xfer_cnt - start), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_byte",  64'(out_byte),  64'd0);
    chk("async_rst_cnt",   64'(byte_cnt),  64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(32'd1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/leb128_u32_stream_encoder.md
LEB128_U32_STREAM_ENCODER -- requirements
Module: leb128_u32_stream_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: a value is offered.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder can accept a value this cycle.
REQ-005 SHALL have port in_data, input, 32 bits: value to encode.
REQ-006 SHALL have port in_signed, input, 1 bit: 1 = signed LEB128 (two's complement in_data), 0 = unsigned; sampled with in_data.
REQ-007 SHALL have port out_valid, output, 1 bit: out_byte holds a valid encoded byte.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes out_byte this cycle.
REQ-009 SHALL have port out_byte, output, 8 bits: encoded byte; bit7 = continuation flag, bits[6:0] = payload group.
REQ-010 SHALL have port out_last, output, 1 bit: out_byte is the final byte of the current encoding (bit7 = 0).
REQ-011 SHALL have port byte_cnt, output, 3 bits: total encoded length (1..5); valid whenever out_valid=1.

Function
REQ-012 SHALL accept a value on a cycle where in_valid=1 and in_ready=1, latching in_data and in_signed.
REQ-013 SHALL have FSM states IDLE and EMIT; IDLE->EMIT on accept; EMIT->IDLE when the last byte transfers and no new value is accepted in the same cycle.
REQ-014 SHALL drive in_ready=1 in IDLE, and in EMIT only in a cycle where out_valid=1, out_last=1 and out_ready=1 (this permits back-to-back encodings with no bubble).
REQ-015 SHALL present the first byte with out_valid=1 on the cycle after accept (1-cycle latency), with one byte per cycle while out_ready=1.
REQ-016 SHALL hold out_byte, out_last and byte_cnt stable while out_valid=1 and out_ready=0.
REQ-017 Group k (k=0..4) SHALL be value bits[7k+6:7k], LSB group first; group 4 SHALL be bits[31:28] zero-extended (unsigned) or sign-extended from bit31 (signed) to 7 bits.
REQ-018 Unsigned: the encoding SHALL end at the first group k where value>>(7k+7) == 0; the minimum length is 1 (value 0 -> 0x00).
REQ-019 Signed: the encoding SHALL end at the first group k where the arithmetic value>>(7k+7) is 0 with group bit6=0, or is all-ones with group bit6=1.
REQ-020 Group 4 SHALL always be last, giving a maximum of 5 bytes.
REQ-021 SHALL compute byte_cnt at accept time from the latched value; it SHALL be constant for all bytes of one encoding.
REQ-022 out_byte bit7 SHALL be 1 for every byte except the last, for which it SHALL be 0.
REQ-023 SHALL ignore in_data and in_signed changes while in EMIT except on an accept cycle.

Reset
REQ-024 SHALL, on rst_n=0 and independent of clk: set state=IDLE, out_valid=0, out_last=0, out_byte=0x00, byte_cnt=0, and the internal shift/index registers to 0.
REQ-025 SHALL, on reset mid-encoding, drop the remaining bytes; the first value accepted after reset SHALL encode from group 0.
REQ-026 SHALL hold in_ready=1 in the first cycle after reset release.

Verification
REQ-027 Unsigned 624485 -> E5 8E 26, byte_cnt=3, out_last on the 3rd byte only.
REQ-028 Unsigned 0xFFFFFFFF -> FF FF FF FF 0F (byte_cnt=5); unsigned 0 -> 00 (byte_cnt=1).
REQ-029 Signed -123456 -> C0 BB 78; signed -1 -> 7F; signed 64 -> C0 00; signed 0x80000000 -> 80 80 80 80 78.
REQ-030 Backpressure: out_ready toggled randomly during a 5-byte encoding -> bytes held stable while stalled, with no loss or duplication.
REQ-031 Back-to-back: a second value offered while the last byte of the first transfers -> accepted in the same cycle, and its first byte follows on the next cycle.
REQ-032 Reset asserted after the 2nd byte of a 5-byte encoding -> out_valid=0 immediately; after release, value 1 encodes as 01.
